// File: rtl/io_bus_arbiter_if.sv
// Two-master IO bus arbiter handshake bundle: master-side strobes/acks plus the IO register bus.
// The arbiter connects through the slave modport; a requester or bench drives through master.
interface io_bus_arbiter_if;
  logic m0_strobe;
  logic m1_strobe;
  logic m0_write;
  logic m1_write;
  logic m0_ack;
  logic m1_ack;
  logic m0_err;
  logic m1_err;
  logic io_rd_ack;
  logic io_rd_en;
  logic io_wr_en;
  logic io_sync;
  logic io_sel;

  modport master (
    output m0_strobe, m1_strobe, m0_write, m1_write, io_rd_ack,
    input  m0_ack, m1_ack, m0_err, m1_err, io_rd_en, io_wr_en, io_sync, io_sel
  );

  modport slave (
    input  m0_strobe, m1_strobe, m0_write, m1_write, io_rd_ack,
    output m0_ack, m1_ack, m0_err, m1_err, io_rd_en, io_wr_en, io_sync, io_sel
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter giving two masters access to an IO register bus, with registered outputs.
// Define IO_ARB_TIMEOUT_EN to add an RD_WAIT timeout that completes the read with an error flag.
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned HOLD_CYCLES    = 3
) (
  input logic             clk,
  input logic             res,
  io_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StGrant, StWrEn, StRdWait, StRdDly1, StRdDly2, StAck, StHold
  } state_e;

  state_e     state_q;
  logic       last_served_q;
  logic       owner_q;
  logic       write_q;
  logic [3:0] hold_cnt_q;
  logic       m0_ack_q, m1_ack_q;
  logic       rd_en_q, wr_en_q, sync_q;
  logic       grant_owner;
  logic       grant_write;

  // Tie goes to whichever master was not served last.
  assign grant_owner = (bus.m0_strobe && bus.m1_strobe) ? ~last_served_q : bus.m1_strobe;
  assign grant_write = grant_owner ? bus.m1_write : bus.m0_write;

`ifdef IO_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       m0_err_q, m1_err_q;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      owner_q       <= 1'b0;
      write_q       <= 1'b0;
      hold_cnt_q    <= 4'd0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      sync_q        <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
      tmo_cnt_q     <= 8'd0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
`endif
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      wr_en_q  <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.m0_strobe || bus.m1_strobe) begin
            state_q       <= StGrant;
            owner_q       <= grant_owner;
            last_served_q <= grant_owner;
            write_q       <= grant_write;
            sync_q        <= 1'b1;
            rd_en_q       <= ~grant_write;
          end
        end
        StGrant: begin
          if (write_q) begin
            state_q <= StWrEn;
            wr_en_q <= 1'b1;
          end else begin
            state_q <= StRdWait;
`ifdef IO_ARB_TIMEOUT_EN
            tmo_cnt_q <= 8'd0;
`endif
          end
        end
        StWrEn: begin
          state_q  <= StAck;
          m0_ack_q <= ~owner_q;
          m1_ack_q <= owner_q;
        end
        StRdWait: begin
          // A late io_rd_ack on the timeout edge still wins over the timeout.
          if (bus.io_rd_ack) begin
            state_q <= StRdDly1;
`ifdef IO_ARB_TIMEOUT_EN
          end else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES)) begin
            state_q  <= StAck;
            m0_ack_q <= ~owner_q;
            m1_ack_q <= owner_q;
            m0_err_q <= ~owner_q;
            m1_err_q <= owner_q;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        StRdDly1: state_q <= StRdDly2;
        StRdDly2: begin
          state_q  <= StAck;
          m0_ack_q <= ~owner_q;
          m1_ack_q <= owner_q;
        end
        StAck: begin
          state_q    <= StHold;
          hold_cnt_q <= 4'(HOLD_CYCLES - 1);
        end
        StHold: begin
          if (hold_cnt_q == 4'd0) begin
            state_q <= StIdle;
            sync_q  <= 1'b0;
            owner_q <= 1'b0;
            rd_en_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.io_rd_en = rd_en_q;
  assign bus.io_wr_en = wr_en_q;
  assign bus.io_sync  = sync_q;
  assign bus.io_sel   = owner_q;

`ifdef IO_ARB_TIMEOUT_EN
  assign bus.m0_err = m0_err_q;
  assign bus.m1_err = m1_err_q;
`else
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

endmodule
